gem_copad_clct_pri_gen: RTL and testbench

- Upstream stage of the GEM-CLCT best-copad tree sorter.
- Buffers the 8 GEM copad clusters (key position xky, 10 bits each) over a short BX window.
- On each CLCT pre-trigger strobe, computes one priority per copad slot: the bending angle |clct_xky - gem_xky|.
- Presents registered win_pri_0..7 / gem_xky_0..7 with a valid strobe. The downstream sorter picks the smallest.

---
 rtl/gem_copad_clct_pri_gen.sv | 183 ++++++++++++++++++
 tb/tb_gem_copad_clct_pri_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gem_copad_clct_pri_gen.sv
// GEM copad / CLCT priority generator.
// Keeps a short per-slot history of GEM copad key positions. On each CLCT
// pre-trigger it registers, for every slot, the bending angle |clct - gem|
// of that slot's youngest valid copad. 10'h3FF marks "no match".
module gem_copad_clct_pri_gen #(
    parameter int         WIN       = 3,       // window depth in BX incl. current, 1..4
    parameter logic [9:0] MAX_DXKY  = 10'd64,  // largest accepted |dxky|
    parameter bit         KILL_USED = 1'b1     // consume the copad that matched
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] copad_vld,
    input  logic [9:0] copad_xky_0,
    input  logic [9:0] copad_xky_1,
    input  logic [9:0] copad_xky_2,
    input  logic [9:0] copad_xky_3,
    input  logic [9:0] copad_xky_4,
    input  logic [9:0] copad_xky_5,
    input  logic [9:0] copad_xky_6,
    input  logic [9:0] copad_xky_7,
    input  logic       clct_vpf,
    input  logic [9:0] clct_xky,
    output logic [9:0] win_pri_0,
    output logic [9:0] win_pri_1,
    output logic [9:0] win_pri_2,
    output logic [9:0] win_pri_3,
    output logic [9:0] win_pri_4,
    output logic [9:0] win_pri_5,
    output logic [9:0] win_pri_6,
    output logic [9:0] win_pri_7,
    output logic [9:0] gem_xky_0,
    output logic [9:0] gem_xky_1,
    output logic [9:0] gem_xky_2,
    output logic [9:0] gem_xky_3,
    output logic [9:0] gem_xky_4,
    output logic [9:0] gem_xky_5,
    output logic [9:0] gem_xky_6,
    output logic [9:0] gem_xky_7,
    output logic       pri_vld,
    output logic       any_match
);

    // History depth; one dummy entry is kept when WIN=1 so the arrays are never empty.
    localparam int HD = (WIN > 1) ? WIN - 1 : 1;
    localparam logic [9:0] NO_MATCH = 10'h3FF;

    logic [9:0] copad_xky [8];

    logic       hist_vld_q [8][HD];
    logic       hist_vld_d [8][HD];
    logic [9:0] hist_xky_q [8][HD];
    logic [9:0] hist_xky_d [8][HD];

    logic [9:0] win_pri_q [8];
    logic [9:0] win_pri_d [8];
    logic [9:0] gem_xky_q [8];
    logic [9:0] gem_xky_d [8];
    logic       pri_vld_q, pri_vld_d;
    logic       any_match_q, any_match_d;

    logic       sel_vld [8];
    logic [9:0] sel_xky [8];
    logic [1:0] sel_age [8];
    logic [9:0] dxky    [8];
    logic       match   [8];

    assign copad_xky[0] = copad_xky_0;
    assign copad_xky[1] = copad_xky_1;
    assign copad_xky[2] = copad_xky_2;
    assign copad_xky[3] = copad_xky_3;
    assign copad_xky[4] = copad_xky_4;
    assign copad_xky[5] = copad_xky_5;
    assign copad_xky[6] = copad_xky_6;
    assign copad_xky[7] = copad_xky_7;

    // Pick the youngest valid candidate per slot and measure its distance to the CLCT.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            sel_vld[i] = 1'b0;
            sel_xky[i] = 10'd0;
            sel_age[i] = 2'd0;
            // Walk oldest to youngest so a younger valid entry overrides an older one.
            for (int a = WIN - 1; a >= 1; a--) begin
                if (hist_vld_q[i][a-1]) begin
                    sel_vld[i] = 1'b1;
                    sel_xky[i] = hist_xky_q[i][a-1];
                    sel_age[i] = 2'(a);
                end
            end
            if (copad_vld[i]) begin
                sel_vld[i] = 1'b1;
                sel_xky[i] = copad_xky[i];
                sel_age[i] = 2'd0;
            end
            dxky[i]  = (clct_xky >= sel_xky[i]) ? (clct_xky - sel_xky[i])
                                                : (sel_xky[i] - clct_xky);
            match[i] = sel_vld[i] && (dxky[i] <= MAX_DXKY);
        end
    end

    // Shift the history one BX; a copad consumed by this strobe moves on invalidated.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            logic kill;
            kill = KILL_USED && clct_vpf && match[i];
            for (int a = 0; a < HD; a++) begin
                hist_vld_d[i][a] = hist_vld_q[i][a];
                hist_xky_d[i][a] = hist_xky_q[i][a];
            end
            hist_vld_d[i][0] = copad_vld[i] && !(kill && sel_age[i] == 2'd0);
            hist_xky_d[i][0] = copad_xky[i];
            for (int a = 1; a < WIN - 1; a++) begin
                hist_vld_d[i][a] = hist_vld_q[i][a-1] && !(kill && sel_age[i] == 2'(a));
                hist_xky_d[i][a] = hist_xky_q[i][a-1];
            end
        end
    end

    // Load new priorities on a strobe, otherwise hold them.
    always_comb begin
        pri_vld_d   = clct_vpf;
        any_match_d = any_match_q;
        for (int i = 0; i < 8; i++) begin
            win_pri_d[i] = win_pri_q[i];
            gem_xky_d[i] = gem_xky_q[i];
        end
        if (clct_vpf) begin
            any_match_d = 1'b0;
            for (int i = 0; i < 8; i++) begin
                win_pri_d[i] = match[i] ? dxky[i]    : NO_MATCH;
                gem_xky_d[i] = match[i] ? sel_xky[i] : 10'd0;
                any_match_d  = any_match_d | match[i];
            end
        end
    end

    // Control state and output registers; reset wins over a simultaneous strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            pri_vld_q   <= 1'b0;
            any_match_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                win_pri_q[i] <= NO_MATCH;
                gem_xky_q[i] <= 10'd0;
                for (int a = 0; a < HD; a++) hist_vld_q[i][a] <= 1'b0;
            end
        end else begin
            pri_vld_q   <= pri_vld_d;
            any_match_q <= any_match_d;
            for (int i = 0; i < 8; i++) begin
                win_pri_q[i] <= win_pri_d[i];
                gem_xky_q[i] <= gem_xky_d[i];
                for (int a = 0; a < HD; a++) hist_vld_q[i][a] <= hist_vld_d[i][a];
            end
        end
    end

    // History key positions are data only; their valid bits gate them.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 8; i++)
            for (int a = 0; a < HD; a++) hist_xky_q[i][a] <= hist_xky_d[i][a];
    end

    assign pri_vld   = pri_vld_q;
    assign any_match = any_match_q;
    assign win_pri_0 = win_pri_q[0];
    assign win_pri_1 = win_pri_q[1];
    assign win_pri_2 = win_pri_q[2];
    assign win_pri_3 = win_pri_q[3];
    assign win_pri_4 = win_pri_q[4];
    assign win_pri_5 = win_pri_q[5];
    assign win_pri_6 = win_pri_q[6];
    assign win_pri_7 = win_pri_q[7];
    assign gem_xky_0 = gem_xky_q[0];
    assign gem_xky_1 = gem_xky_q[1];
    assign gem_xky_2 = gem_xky_q[2];
    assign gem_xky_3 = gem_xky_q[3];
    assign gem_xky_4 = gem_xky_q[4];
    assign gem_xky_5 = gem_xky_q[5];
    assign gem_xky_6 = gem_xky_q[6];
    assign gem_xky_7 = gem_xky_q[7];

endmodule

// File: tb/tb_gem_copad_clct_pri_gen.sv
// Directed bench for gem_copad_clct_pri_gen: a KILL_USED=1 instance (a) and a
// KILL_USED=0 instance (b) share all inputs.
module tb_gem_copad_clct_pri_gen;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] copad_vld;
    logic [9:0] cx [8];
    logic       clct_vpf;
    logic [9:0] clct_xky;

    logic [9:0] pri_a [8];
    logic [9:0] gem_a [8];
    logic       vld_a, any_a;
    logic [9:0] pri_b [8];
    logic [9:0] gem_b [8];
    logic       vld_b, any_b;

    logic [9:0] exp_pri [8];
    logic [9:0] exp_gem [8];

    int n_checks = 0;
    int n_fail   = 0;

    always #12 clock = ~clock;

    gem_copad_clct_pri_gen #(.WIN(3), .MAX_DXKY(10'd64), .KILL_USED(1'b1)) dut_a (
        .clock(clock), .reset(reset), .copad_vld(copad_vld),
        .copad_xky_0(cx[0]), .copad_xky_1(cx[1]), .copad_xky_2(cx[2]), .copad_xky_3(cx[3]),
        .copad_xky_4(cx[4]), .copad_xky_5(cx[5]), .copad_xky_6(cx[6]), .copad_xky_7(cx[7]),
        .clct_vpf(clct_vpf), .clct_xky(clct_xky),
        .win_pri_0(pri_a[0]), .win_pri_1(pri_a[1]), .win_pri_2(pri_a[2]), .win_pri_3(pri_a[3]),
        .win_pri_4(pri_a[4]), .win_pri_5(pri_a[5]), .win_pri_6(pri_a[6]), .win_pri_7(pri_a[7]),
        .gem_xky_0(gem_a[0]), .gem_xky_1(gem_a[1]), .gem_xky_2(gem_a[2]), .gem_xky_3(gem_a[3]),
        .gem_xky_4(gem_a[4]), .gem_xky_5(gem_a[5]), .gem_xky_6(gem_a[6]), .gem_xky_7(gem_a[7]),
        .pri_vld(vld_a), .any_match(any_a)
    );

    gem_copad_clct_pri_gen #(.WIN(3), .MAX_DXKY(10'd64), .KILL_USED(1'b0)) dut_b (
        .clock(clock), .reset(reset), .copad_vld(copad_vld),
        .copad_xky_0(cx[0]), .copad_xky_1(cx[1]), .copad_xky_2(cx[2]), .copad_xky_3(cx[3]),
        .copad_xky_4(cx[4]), .copad_xky_5(cx[5]), .copad_xky_6(cx[6]), .copad_xky_7(cx[7]),
        .clct_vpf(clct_vpf), .clct_xky(clct_xky),
        .win_pri_0(pri_b[0]), .win_pri_1(pri_b[1]), .win_pri_2(pri_b[2]), .win_pri_3(pri_b[3]),
        .win_pri_4(pri_b[4]), .win_pri_5(pri_b[5]), .win_pri_6(pri_b[6]), .win_pri_7(pri_b[7]),
        .gem_xky_0(gem_b[0]), .gem_xky_1(gem_b[1]), .gem_xky_2(gem_b[2]), .gem_xky_3(gem_b[3]),
        .gem_xky_4(gem_b[4]), .gem_xky_5(gem_b[5]), .gem_xky_6(gem_b[6]), .gem_xky_7(gem_b[7]),
        .pri_vld(vld_b), .any_match(any_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        copad_vld = 8'h00;
        clct_vpf  = 1'b0;
        clct_xky  = 10'd0;
        for (int i = 0; i < 8; i++) cx[i] = 10'd0;
    endtask

    // Let every history entry age out.
    task automatic flush();
        idle_inputs();
        repeat (3) step();
    endtask

    task automatic clr_exp();
        for (int i = 0; i < 8; i++) begin
            exp_pri[i] = 10'h3FF;
            exp_gem[i] = 10'd0;
        end
    endtask

    task automatic chk_a(input string tag);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_a_pri%0d", tag, i), 32'(pri_a[i]), 32'(exp_pri[i]));
            check($sformatf("%s_a_gem%0d", tag, i), 32'(gem_a[i]), 32'(exp_gem[i]));
        end
    endtask

    task automatic chk_b(input string tag);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_b_pri%0d", tag, i), 32'(pri_b[i]), 32'(exp_pri[i]));
            check($sformatf("%s_b_gem%0d", tag, i), 32'(gem_b[i]), 32'(exp_gem[i]));
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        // reset state
        clr_exp();
        check("rst_vld_a", 32'(vld_a), 32'd0);
        check("rst_any_a", 32'(any_a), 32'd0);
        chk_a("rst");
        reset = 1'b0;
        step();

        // 1: strobe with no copads
        clct_vpf = 1'b1; clct_xky = 10'd100;
        step();
        idle_inputs();
        check("t1_vld_a", 32'(vld_a), 32'd1);
        check("t1_any_a", 32'(any_a), 32'd0);
        chk_a("t1");
        step();
        check("t1_vld_drop", 32'(vld_a), 32'd0);

        // 2: same-BX match, 1 clock latency, held afterwards
        copad_vld = 8'b0000_0100; cx[2] = 10'd110;
        clct_vpf = 1'b1; clct_xky = 10'd100;
        step();
        idle_inputs();
        clr_exp(); exp_pri[2] = 10'd10; exp_gem[2] = 10'd110;
        check("t2_vld_a", 32'(vld_a), 32'd1);
        check("t2_any_a", 32'(any_a), 32'd1);
        chk_a("t2");
        chk_b("t2");
        step();
        check("t2_hold_vld", 32'(vld_a), 32'd0);
        check("t2_hold_pri2", 32'(pri_a[2]), 32'd10);
        flush();

        // 3a: copad at t, strobe at t+2 -> still in window
        copad_vld = 8'b0010_0000; cx[5] = 10'd300;
        step();
        idle_inputs();
        step();
        clct_vpf = 1'b1; clct_xky = 10'd290;
        step();
        idle_inputs();
        check("t3a_pri5", 32'(pri_a[5]), 32'd10);
        check("t3a_gem5", 32'(gem_a[5]), 32'd300);
        flush();

        // 3b: strobe at t+3 -> aged out
        copad_vld = 8'b0010_0000; cx[5] = 10'd300;
        step();
        idle_inputs();
        step();
        step();
        clct_vpf = 1'b1; clct_xky = 10'd290;
        step();
        idle_inputs();
        check("t3b_pri5", 32'(pri_a[5]), 32'h3FF);
        check("t3b_any", 32'(any_a), 32'd0);
        flush();

        // 3c: youngest candidate wins even though an older one would match
        copad_vld = 8'b0010_0000; cx[5] = 10'd300;
        step();
        cx[5] = 10'd500;
        clct_vpf = 1'b1; clct_xky = 10'd290;
        step();
        idle_inputs();
        check("t3c_pri5", 32'(pri_a[5]), 32'h3FF);
        check("t3c_gem5", 32'(gem_a[5]), 32'd0);
        check("t3c_any", 32'(any_a), 32'd0);
        flush();

        // 4: threshold edges and zero difference
        copad_vld = 8'b0000_1111;
        cx[0] = 10'd264; cx[1] = 10'd265; cx[2] = 10'd136; cx[3] = 10'd200;
        clct_vpf = 1'b1; clct_xky = 10'd200;
        step();
        idle_inputs();
        clr_exp();
        exp_pri[0] = 10'd64; exp_gem[0] = 10'd264;
        exp_pri[2] = 10'd64; exp_gem[2] = 10'd136;
        exp_pri[3] = 10'd0;  exp_gem[3] = 10'd200;
        chk_a("t4");
        check("t4_any", 32'(any_a), 32'd1);
        flush();
        // no wrap: 0 vs 1023, plus an exact hit at 1023
        copad_vld = 8'b0000_0011; cx[0] = 10'd0; cx[1] = 10'd1023;
        clct_vpf = 1'b1; clct_xky = 10'd1023;
        step();
        idle_inputs();
        clr_exp(); exp_pri[1] = 10'd0; exp_gem[1] = 10'd1023;
        chk_a("t4w");
        flush();

        // 5: KILL_USED consumes the matching copad; back-to-back strobes
        copad_vld = 8'b0000_0001; cx[0] = 10'd50;
        clct_vpf = 1'b1; clct_xky = 10'd50;
        step();
        copad_vld = 8'h00; cx[0] = 10'd0;
        check("t5_s1_pri0_a", 32'(pri_a[0]), 32'd0);
        check("t5_s1_pri0_b", 32'(pri_b[0]), 32'd0);
        step();
        idle_inputs();
        check("t5_s2_vld_a", 32'(vld_a), 32'd1);
        check("t5_s2_vld_b", 32'(vld_b), 32'd1);
        check("t5_s2_pri0_a", 32'(pri_a[0]), 32'h3FF);
        check("t5_s2_gem0_a", 32'(gem_a[0]), 32'd0);
        check("t5_s2_any_a", 32'(any_a), 32'd0);
        check("t5_s2_pri0_b", 32'(pri_b[0]), 32'd0);
        check("t5_s2_gem0_b", 32'(gem_b[0]), 32'd50);
        check("t5_s2_any_b", 32'(any_b), 32'd1);
        flush();

        // 6: reset during back-to-back strobes with full history
        copad_vld = 8'hFF;
        for (int i = 0; i < 8; i++) cx[i] = 10'd400;
        step();
        step();
        copad_vld = 8'h00;
        reset = 1'b1; clct_vpf = 1'b1; clct_xky = 10'd400;
        step();
        check("t6_r1_vld_a", 32'(vld_a), 32'd0);
        check("t6_r1_vld_b", 32'(vld_b), 32'd0);
        step();
        check("t6_r2_vld_a", 32'(vld_a), 32'd0);
        check("t6_r2_pri0_a", 32'(pri_a[0]), 32'h3FF);
        reset = 1'b0;
        step();
        idle_inputs();
        clr_exp();
        check("t6_post_vld_a", 32'(vld_a), 32'd1);
        check("t6_post_any_a", 32'(any_a), 32'd0);
        check("t6_post_any_b", 32'(any_b), 32'd0);
        chk_a("t6");
        chk_b("t6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
